// File: rtl/as_pack.sv
// Shared constants and types for the GPIO port: register map, pad count, cs FSM states.
package as_pack;

    localparam int nr_gpios        = 8;
    localparam int gpio_addr_width = 4;

    localparam logic [3:0] GPIO_OUT_OFS  = 4'h0;
    localparam logic [3:0] GPIO_DIR_OFS  = 4'h4;
    localparam logic [3:0] GPIO_IN_OFS   = 4'h8;
    localparam logic [3:0] GPIO_STAT_OFS = 4'hC;

    typedef enum logic {
        CS_IDLE,
        CS_ACTIVE
    } cs_state_t;

    // Only addr[3:2] selects a register; the byte lane bits are dropped.
    function automatic logic [3:0] reg_ofs(input logic [3:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/as_gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; latency STAGES cycles, no backpressure.
module as_gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port with cs strobe; optional edge interrupts under GPIO_EDGE_IRQ_EN.
// Load latency 1 cycle, no backpressure: every we_i/re_i strobe is accepted on its edge.
module as_gpio_port
    import as_pack::*;
#(
    parameter int DATA_W      = 64,
    parameter int NR_GPIOS    = nr_gpios,
    parameter int ADDR_W      = gpio_addr_width,
    parameter int CS_PULSE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);

    localparam logic [3:0] CNT_LOAD = 4'(CS_PULSE - 1);

    logic [3:0]          ofs;
    logic                wr_out;
    logic                wr_dir;
    logic [NR_GPIOS-1:0] out_q;
    logic [NR_GPIOS-1:0] dir_q;
    logic [NR_GPIOS-1:0] in_sync;
    logic [NR_GPIOS-1:0] stat_w;
    logic [NR_GPIOS-1:0] rd_mux;
    cs_state_t           state_q;
    logic [3:0]          cnt_q;
    logic                unused_bits;

    assign ofs    = reg_ofs(addr_i[3:0]);
    assign wr_out = we_i && (ofs == GPIO_OUT_OFS);
    assign wr_dir = we_i && (ofs == GPIO_DIR_OFS);

    // Only the decoded bits and the low NR_GPIOS data bits carry meaning.
    assign unused_bits = ^{addr_i, wdata_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
            dir_q <= '0;
        end else begin
            if (wr_out) out_q <= wdata_i[NR_GPIOS-1:0];
            if (wr_dir) dir_q <= wdata_i[NR_GPIOS-1:0];
        end
    end

    for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Samples the resolved pad, so driven outputs read back too.
    as_gpio_sync #(
        .WIDTH  (NR_GPIOS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gpio_io),
        .q_o   (in_sync)
    );

`ifdef GPIO_EDGE_IRQ_EN
    logic [NR_GPIOS-1:0] prev_q;
    logic [NR_GPIOS-1:0] stat_q;
    logic [NR_GPIOS-1:0] clr;
    logic                irq_q;

    assign clr = (we_i && (ofs == GPIO_STAT_OFS)) ? wdata_i[NR_GPIOS-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= in_sync;
            // A new edge in the same cycle as its clear keeps the bit set.
            stat_q <= (stat_q & ~clr) | (in_sync & ~prev_q);
            irq_q  <= |stat_q;
        end
    end

    assign stat_w = stat_q;
    assign irq_o  = irq_q;
`else
    assign stat_w = '0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (ofs)
            GPIO_OUT_OFS:  rd_mux = out_q;
            GPIO_DIR_OFS:  rd_mux = dir_q;
            GPIO_IN_OFS:   rd_mux = in_sync;
            GPIO_STAT_OFS: rd_mux = stat_w;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            if (re_i) rdata_o <= DATA_W'(rd_mux);
        end
    end

    // cs_o rises with the new pad value; a store while active reloads the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            cs_o    <= 1'b0;
        end else begin
            case (state_q)
                CS_IDLE: begin
                    if (wr_out) begin
                        state_q <= CS_ACTIVE;
                        cnt_q   <= CNT_LOAD;
                        cs_o    <= 1'b1;
                    end
                end
                CS_ACTIVE: begin
                    if (wr_out) begin
                        cnt_q <= CNT_LOAD;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= CS_IDLE;
                        cs_o    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= CS_IDLE;
                    cs_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_as_gpio_port.sv
// Directed bench for as_gpio_port: one instance with CS_PULSE=1, one with CS_PULSE=4.
module tb_as_gpio_port;

`ifdef GPIO_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic        cs_a, cs_b;
    logic        irq_a, irq_b;
    wire  [7:0]  gpio_a;
    wire  [7:0]  gpio_b;
    logic [7:0]  drv_en;
    logic [7:0]  drv_val;

    int n_checks = 0;
    int n_fail   = 0;

    int hi_a = 0, rise_a = 0, hi_b = 0, rise_b = 0;
    int base_hi_a, base_rise_a, base_hi_b, base_rise_b;
    logic prev_cs_a = 1'b0, prev_cs_b = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign gpio_a[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end

    as_gpio_port #(.CS_PULSE(1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (we),
        .re_i     (re),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata_a),
        .rvalid_o (rvalid_a),
        .gpio_io  (gpio_a),
        .cs_o     (cs_a),
        .irq_o    (irq_a)
    );

    as_gpio_port #(.CS_PULSE(4)) dut_p4 (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (we),
        .re_i     (re),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata_b),
        .rvalid_o (rvalid_b),
        .gpio_io  (gpio_b),
        .cs_o     (cs_b),
        .irq_o    (irq_b)
    );

    // cs high-cycle and rising-edge tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (cs_a) hi_a++;
        if (cs_a && !prev_cs_a) rise_a++;
        prev_cs_a = cs_a;
        if (cs_b) hi_b++;
        if (cs_b && !prev_cs_b) rise_b++;
        prev_cs_b = cs_b;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d);
        we = 1'b1; addr = a; wdata = d;
        step(1);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        re = 1'b1; addr = a;
        step(1);
        re = 1'b0;
    endtask

    task automatic wrd(input logic [3:0] a, input logic [63:0] d);
        we = 1'b1; re = 1'b1; addr = a; wdata = d;
        step(1);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic mark_cs;
        base_hi_a = hi_a; base_rise_a = rise_a;
        base_hi_b = hi_b; base_rise_b = rise_b;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 4'h0; wdata = '0;
        drv_en = 8'hFF; drv_val = 8'h00;
        step(3);
        check("reset_cs", {63'd0, cs_a}, 64'd0);
        check("reset_rvalid", {63'd0, rvalid_a}, 64'd0);
        check("reset_rdata", rdata_a, 64'd0);
        check("reset_irq", {63'd0, irq_a}, 64'd0);
        rst = 1'b0;
        step(2);

        // Single OUT store: pad and cs appear together, one cycle wide.
        mark_cs();
        drv_en = 8'h80;
        wr(4'h4, 64'h7F);
        check("dir_store_no_cs", {63'd0, cs_a}, 64'd0);
        wr(4'h0, 64'h1);
        check("out1_pad", {56'd0, gpio_a}, 64'h01);
        check("out1_cs_high", {63'd0, cs_a}, 64'd1);
        step(1);
        check("out1_cs_low", {63'd0, cs_a}, 64'd0);
        step(6);
        check("out1_cs_cycles", 64'(hi_a - base_hi_a), 64'd1);
        check("out1_cs_rises", 64'(rise_a - base_rise_a), 64'd1);
        check("out1_p4_cycles", 64'(hi_b - base_hi_b), 64'd4);

        // Back-to-back stores: cs stays high, pads follow each store.
        mark_cs();
        wr(4'h0, 64'h3);
        check("b2b_pad3", {56'd0, gpio_a}, 64'h03);
        wr(4'h0, 64'h5);
        check("b2b_pad5", {56'd0, gpio_a}, 64'h05);
        wr(4'h0, 64'h7);
        check("b2b_pad7", {56'd0, gpio_a}, 64'h07);
        check("b2b_cs_high", {63'd0, cs_a}, 64'd1);
        step(1);
        check("b2b_cs_low", {63'd0, cs_a}, 64'd0);
        step(8);
        check("b2b_cs_cycles", 64'(hi_a - base_hi_a), 64'd3);
        check("b2b_cs_rises", 64'(rise_a - base_rise_a), 64'd1);
        check("b2b_p4_cycles", 64'(hi_b - base_hi_b), 64'd6);

        // Retrigger two cycles later on the 4-cycle instance.
        mark_cs();
        wr(4'h0, 64'h11);
        step(1);
        wr(4'h0, 64'h22);
        step(10);
        check("retrig_p4_cycles", 64'(hi_b - base_hi_b), 64'd6);
        check("retrig_p4_rises", 64'(rise_b - base_rise_b), 64'd1);
        check("retrig_p1_rises", 64'(rise_a - base_rise_a), 64'd2);

        // Mixed direction: upper pads from bench, lower from OUT.
        wr(4'h4, 64'h0F);
        drv_en = 8'hF0; drv_val = 8'hA0;
        #1;
        check("mixed_pad", {56'd0, gpio_a}, 64'hA2);
        rd(4'h8);
        check("in_stale_1", rdata_a, 64'h22);
        rd(4'h8);
        check("in_stale_2", rdata_a, 64'h22);
        rd(4'h8);
        check("in_synced", rdata_a, 64'hA2);
        check("in_rvalid", {63'd0, rvalid_a}, 64'd1);
        step(1);
        check("rvalid_drop", {63'd0, rvalid_a}, 64'd0);
        rd(4'h0);
        check("rd_out", rdata_a, 64'h22);
        rd(4'h4);
        check("rd_dir", rdata_a, 64'h0F);
        wr(4'h8, 64'hFF);
        rd(4'h8);
        check("in_write_ignored", rdata_a, 64'hA2);
        wrd(4'h0, 64'h33);
        check("rw_pre_value", rdata_a, 64'h22);

        // Reset during an active pulse.
        wrd(4'h0, 64'h44);
        check("pre_rst_cs", {63'd0, cs_b}, 64'd1);
        check("pre_rst_rdata", rdata_a, 64'h33);
        #1;
        rst = 1'b1;
        #1;
        check("rst_cs_a", {63'd0, cs_a}, 64'd0);
        check("rst_cs_b", {63'd0, cs_b}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid_a}, 64'd0);
        check("rst_rdata", rdata_a, 64'd0);
        drv_en = 8'hFF; drv_val = 8'h5A;
        #1;
        check("rst_pads_released", {56'd0, gpio_a}, 64'h5A);
        step(2);
        rst = 1'b0;
        rd(4'h0);
        check("post_rst_out", rdata_a, 64'd0);
        rd(4'h4);
        check("post_rst_dir", rdata_a, 64'd0);
        rd(4'h8);
        check("post_rst_in", rdata_a, 64'h5A);

        // Edge pending / interrupt.
        drv_val = 8'h00;
        step(4);
        wr(4'hC, 64'hFF);
        step(2);
        rd(4'hC);
        check("stat_cleared", rdata_a, 64'd0);
        check("irq_idle", {63'd0, irq_a}, 64'd0);
        drv_val = 8'h10;
        step(4);
        check("irq_on_edge", {63'd0, irq_a}, IRQ_EN ? 64'd1 : 64'd0);
        rd(4'hC);
        check("stat_edge", rdata_a, IRQ_EN ? 64'h10 : 64'h0);
        wr(4'hC, 64'h10);
        step(1);
        check("irq_after_clear", {63'd0, irq_a}, 64'd0);
        rd(4'hC);
        check("stat_after_clear", rdata_a, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
